// File: rtl/booth_control_fsm.sv
// Radix-2 Booth multiplier sequencer: load, N x (eval/add-sub/shift), done.
// Ports: clk, rst (sync high), start, Q0/Q1 booth pair in;
//   LoadA, LoadB, rs, LoadAdd, SEL, Shift, busy, done strobes out.
// Optional: define BOOTH_ABORT_EN to add the abort input.
module booth_control_fsm #(
    parameter int N = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
`ifdef BOOTH_ABORT_EN
    input  logic abort,
`endif
    input  logic Q0,
    input  logic Q1,
    output logic LoadA,
    output logic LoadB,
    output logic rs,
    output logic LoadAdd,
    output logic SEL,
    output logic Shift,
    output logic busy,
    output logic done
);

    localparam int CW = $clog2(N) + 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_EVAL  = 3'd2,
        S_ADD   = 3'd3,
        S_SHIFT = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          op_q, op_d;
    logic          load_q, load_d;
    logic          rs_q, rs_d;
    logic          ladd_q, ladd_d;
    logic          sel_q, sel_d;
    logic          shift_q, shift_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          abort_hit;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        abort_hit = 1'b0;
        case (state_q)
            S_IDLE: if (start) state_d = S_LOAD;
            S_LOAD: begin
                cnt_d   = '0;
                state_d = S_EVAL;
            end
            S_EVAL: begin
                case ({Q0, Q1})
                    2'b10: begin
                        op_d    = 1'b1;
                        state_d = S_ADD;
                    end
                    2'b01: begin
                        op_d    = 1'b0;
                        state_d = S_ADD;
                    end
                    default: state_d = S_SHIFT;
                endcase
            end
            S_ADD: state_d = S_SHIFT;
            S_SHIFT: begin
                if (cnt_q == CW'(N - 1)) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                    state_d = S_EVAL;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
`ifdef BOOTH_ABORT_EN
        // Abort overrides every transition; leaves a one-cycle clear.
        if (abort && state_q != S_IDLE) begin
            state_d   = S_IDLE;
            abort_hit = 1'b1;
        end
`endif
    end

    // Outputs are decoded from the next state so they register with it.
    always_comb begin
        load_d  = 1'b0;
        rs_d    = abort_hit;
        ladd_d  = 1'b0;
        sel_d   = 1'b0;
        shift_d = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        case (state_d)
            S_LOAD: begin
                load_d = 1'b1;
                rs_d   = 1'b1;
                busy_d = 1'b1;
            end
            S_EVAL: busy_d = 1'b1;
            S_ADD: begin
                ladd_d = 1'b1;
                sel_d  = op_d;
                busy_d = 1'b1;
            end
            S_SHIFT: begin
                shift_d = 1'b1;
                busy_d  = 1'b1;
            end
            S_DONE: begin
                done_d = 1'b1;
                busy_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= 1'b0;
            load_q  <= 1'b0;
            rs_q    <= 1'b0;
            ladd_q  <= 1'b0;
            sel_q   <= 1'b0;
            shift_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            load_q  <= load_d;
            rs_q    <= rs_d;
            ladd_q  <= ladd_d;
            sel_q   <= sel_d;
            shift_q <= shift_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign LoadA   = load_q;
    assign LoadB   = load_q;
    assign rs      = rs_q;
    assign LoadAdd = ladd_q;
    assign SEL     = sel_q;
    assign Shift   = shift_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule
